// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multi-operand XOR reducer.
//   state_t      : reducer control states (IDLE / ACCUM / DONE)
//   MODE_XOR     : result is the plain XOR of all operands
//   MODE_XNOR    : result is the bitwise inverse of the XOR
//   apply_mode() : applies the latched mode to an accumulated value
// -----------------------------------------------------------------------------
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic MODE_XOR  = 1'b0;
    localparam logic MODE_XNOR = 1'b1;

    // Applies the output polarity selected by the latched mode bit.
    function automatic logic [63:0] apply_mode(input logic [63:0] value, input logic md);
        return (md == MODE_XNOR) ? ~value : value;
    endfunction

endpackage

// File: rtl/xor_two.sv
// -----------------------------------------------------------------------------
// xor_two
// Purely combinational bitwise XOR of two operands.
//   a : first operand  (width bits)
//   b : second operand (width bits)
//   y : a ^ b          (width bits)
// -----------------------------------------------------------------------------
module xor_two #(
    parameter int width = 32
) (
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic [width-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_multi.sv
// -----------------------------------------------------------------------------
// xor_multi
// Folds a stream of operand beats into a single XOR (or XNOR) result.
// A reduction closes on in_last, or when max_ops operands have been folded
// (flagged by truncated). The result is held until the consumer accepts it.
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operand beat offered
//   in_ready  : block accepts an operand this cycle (IDLE / ACCUM)
//   input1    : operand data
//   in_last   : final operand of the current reduction
//   mode      : 0 = XOR, 1 = XNOR; sampled on the first beat only
//   result    : reduced value, valid in DONE, 0 otherwise
//   out_valid : result available (DONE)
//   out_ready : consumer takes the result
//   count     : operands folded into the current reduction
//   truncated : reduction closed by the max_ops limit rather than in_last
// -----------------------------------------------------------------------------
module xor_multi
    import cpu_pkg::*;
#(
    parameter int width   = 32,
    parameter int max_ops = 16,
    parameter int cnt_w   = $clog2(max_ops + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] input1,
    input  logic             in_last,
    input  logic             mode,
    output logic [width-1:0] result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [cnt_w-1:0] count,
    output logic             truncated
);

    localparam logic [cnt_w-1:0] MAX_CNT = cnt_w'(max_ops);
    localparam logic [cnt_w-1:0] ONE_CNT = cnt_w'(1);

    state_t           state_q, state_d;
    logic [width-1:0] acc_q,   acc_d;
    logic [cnt_w-1:0] count_q, count_d;
    logic             mode_q,  mode_d;
    logic             trunc_q, trunc_d;

    logic [width-1:0] fold_a;
    logic [width-1:0] fold_y;
    logic             accept;
    logic [cnt_w-1:0] count_inc;
    logic [63:0]      moded;

    // The first beat of a reduction folds against zero, so the same XOR
    // path serves both the load and the accumulate case.
    assign fold_a = (state_q == ST_ACCUM) ? acc_q : '0;

    xor_two #(
        .width (width)
    ) u_xor_two (
        .a (fold_a),
        .b (input1),
        .y (fold_y)
    );

    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign count_inc = (state_q == ST_ACCUM) ? (count_q + 1'b1) : ONE_CNT;

    // Result is driven only from registered state, never from input1.
    assign moded     = apply_mode(64'(acc_q), mode_q);
    assign result    = out_valid ? moded[width-1:0] : '0;
    assign truncated = out_valid && trunc_q;
    assign count     = count_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        mode_d  = mode_q;
        trunc_d = trunc_q;

        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    acc_d   = fold_y;
                    count_d = count_inc;
                    if (state_q == ST_IDLE) begin
                        mode_d = mode;
                    end
                    // in_last wins over the limit: a reduction that ends
                    // exactly at max_ops with in_last is not truncated.
                    if (in_last) begin
                        state_d = ST_DONE;
                        trunc_d = 1'b0;
                    end else if (count_inc == MAX_CNT) begin
                        state_d = ST_DONE;
                        trunc_d = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    mode_d  = MODE_XOR;
                    trunc_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                count_d = '0;
                mode_d  = MODE_XOR;
                trunc_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            mode_q  <= MODE_XOR;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            trunc_q <= trunc_d;
        end
    end

endmodule

// File: tb/tb_xor_multi.sv
// -----------------------------------------------------------------------------
// tb_xor_multi
// Directed bench for xor_multi. Two instances share the stimulus bus:
// dut_a uses default parameters (max_ops=16), dut_b uses max_ops=4.
// sel chooses which instance receives in_valid and which is observed.
// -----------------------------------------------------------------------------
module tb_xor_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic [31:0] input1;
    logic        in_last;
    logic        mode;
    logic        out_ready;

    logic        a_in_ready, b_in_ready;
    logic [31:0] a_result,   b_result;
    logic        a_out_valid, b_out_valid;
    logic [4:0]  a_count;
    logic [2:0]  b_count;
    logic        a_trunc,    b_trunc;

    logic        o_in_ready, o_out_valid, o_trunc;
    logic [31:0] o_result;
    logic [7:0]  o_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xor_multi #(.width(32), .max_ops(16), .cnt_w(5)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & ~sel),
        .in_ready  (a_in_ready),
        .input1    (input1),
        .in_last   (in_last),
        .mode      (mode),
        .result    (a_result),
        .out_valid (a_out_valid),
        .out_ready (out_ready & ~sel),
        .count     (a_count),
        .truncated (a_trunc)
    );

    xor_multi #(.width(32), .max_ops(4), .cnt_w(3)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid & sel),
        .in_ready  (b_in_ready),
        .input1    (input1),
        .in_last   (in_last),
        .mode      (mode),
        .result    (b_result),
        .out_valid (b_out_valid),
        .out_ready (out_ready & sel),
        .count     (b_count),
        .truncated (b_trunc)
    );

    assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign o_out_valid = sel ? b_out_valid : a_out_valid;
    assign o_result    = sel ? b_result    : a_result;
    assign o_count     = sel ? {5'd0, b_count} : {3'd0, a_count};
    assign o_trunc     = sel ? b_trunc     : a_trunc;

    typedef struct {
        logic            sel;
        int              n;
        logic [0:3][31:0] beats;
        logic            last;
        logic            md;
        logic [31:0]     exp_result;
        int              exp_count;
        logic            exp_trunc;
    } vec_t;

    localparam int NV = 8;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic md);
        in_valid = 1'b1;
        input1   = d;
        in_last  = last;
        mode     = md;
        tick();
        in_valid = 1'b0;
        input1   = 32'hDEAD_BEEF;
        in_last  = 1'b0;
    endtask

    task automatic check_done(input string tag, input logic [31:0] r, input int c, input logic t);
        check({tag, ".out_valid"}, 64'(o_out_valid), 64'd1);
        check({tag, ".in_ready"},  64'(o_in_ready),  64'd0);
        check({tag, ".result"},    64'(o_result),    64'(r));
        check({tag, ".count"},     64'(o_count),     64'(c));
        check({tag, ".truncated"}, 64'(o_trunc),     64'(t));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".idle_out_valid"}, 64'(o_out_valid), 64'd0);
        check({tag, ".idle_in_ready"},  64'(o_in_ready),  64'd1);
        check({tag, ".idle_count"},     64'(o_count),     64'd0);
        check({tag, ".idle_result"},    64'(o_result),    64'd0);
    endtask

    initial begin
        logic cl;
        int   gap;

        tbl[0] = '{1'b0, 2, {32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0}, 1'b1, 1'b0, 32'hFFFF_FFFF, 2, 1'b0};
        tbl[1] = '{1'b0, 3, {32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0}, 1'b1, 1'b1, 32'h0F0F_0F0F, 3, 1'b0};
        tbl[2] = '{1'b0, 1, {32'h1111_1111, 32'h0, 32'h0, 32'h0}, 1'b1, 1'b0, 32'h1111_1111, 1, 1'b0};
        tbl[3] = '{1'b1, 4, {32'h1, 32'h2, 32'h4, 32'h8}, 1'b0, 1'b0, 32'h0000_000F, 4, 1'b1};
        tbl[4] = '{1'b1, 1, {32'h3, 32'h0, 32'h0, 32'h0}, 1'b1, 1'b0, 32'h0000_0003, 1, 1'b0};
        tbl[5] = '{1'b0, 1, {32'h0000_FFFF, 32'h0, 32'h0, 32'h0}, 1'b1, 1'b1, 32'hFFFF_0000, 1, 1'b0};
        tbl[6] = '{1'b0, 4, {32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 32'h0}, 1'b1, 1'b0, 32'h8888_8888, 4, 1'b0};
        tbl[7] = '{1'b1, 4, {32'hA, 32'h5, 32'h0, 32'h0}, 1'b1, 1'b0, 32'h0000_000F, 4, 1'b0};

        rst       = 1'b1;
        sel       = 1'b0;
        in_valid  = 1'b0;
        input1    = '0;
        in_last   = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            check("reset.in_ready",  64'(o_in_ready),  64'd1);
            check("reset.out_valid", 64'(o_out_valid), 64'd0);
            check("reset.count",     64'(o_count),     64'd0);
            check("reset.result",    64'(o_result),    64'd0);
            check("reset.truncated", 64'(o_trunc),     64'd0);
        end
        $display("reset: checks=%0d failures=%0d", checks, failures);

        // Table vectors; mode is inverted on later beats to prove it is
        // only sampled on the first beat.
        for (int v = 0; v < NV; v++) begin
            sel = tbl[v].sel;
            for (int j = 0; j < tbl[v].n; j++) begin
                cl = tbl[v].last && (j == tbl[v].n - 1);
                check("vec.in_ready_before", 64'(o_in_ready), 64'd1);
                send(tbl[v].beats[j], cl, (j == 0) ? tbl[v].md : ~tbl[v].md);
                if (j != tbl[v].n - 1) begin
                    check("vec.mid_out_valid", 64'(o_out_valid), 64'd0);
                    check("vec.mid_count",     64'(o_count),     64'(j + 1));
                    check("vec.mid_result",    64'(o_result),    64'd0);
                end
            end
            check_done("vec", tbl[v].exp_result, tbl[v].exp_count, tbl[v].exp_trunc);
            handshake("vec");
            $display("vector %0d: sel=%0d beats=%0d result=0x%08h checks=%0d failures=%0d",
                     v, tbl[v].sel, tbl[v].n, tbl[v].exp_result, checks, failures);
        end

        // Held result: consumer stalls 5 cycles while new beats are offered.
        sel = 1'b0;
        send(32'h1111_1111, 1'b1, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            input1   = 32'hCAFE_0000 + 32'(k);
            in_last  = 1'b1;
            check_done("stall", 32'h1111_1111, 1, 1'b0);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_done("stall_end", 32'h1111_1111, 1, 1'b0);
        handshake("stall");
        $display("stall sequence: checks=%0d failures=%0d", checks, failures);

        // Reset in the middle of a reduction, with a beat offered alongside.
        send(32'h3333_3333, 1'b0, 1'b1);
        send(32'h1111_1111, 1'b0, 1'b1);
        check("rstmid.count_before", 64'(o_count), 64'd2);
        rst      = 1'b1;
        in_valid = 1'b1;
        input1   = 32'h7777_7777;
        in_last  = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("rstmid.count",     64'(o_count),     64'd0);
        check("rstmid.out_valid", 64'(o_out_valid), 64'd0);
        check("rstmid.in_ready",  64'(o_in_ready),  64'd1);
        send(32'hAAAA_AAAA, 1'b1, 1'b0);
        check_done("rstmid_next", 32'hAAAA_AAAA, 1, 1'b0);
        handshake("rstmid");
        $display("reset-midstream sequence: checks=%0d failures=%0d", checks, failures);

        // Gaps between beats must not be counted or folded.
        send(32'h5, 1'b0, 1'b0);
        gap = $urandom_range(1, 4);
        for (int k = 0; k < gap; k++) begin
            input1 = $urandom;
            tick();
            check("gap.count",     64'(o_count),     64'd1);
            check("gap.out_valid", 64'(o_out_valid), 64'd0);
        end
        send(32'h6, 1'b1, 1'b0);
        check_done("gap", 32'h3, 2, 1'b0);
        handshake("gap");
        $display("gap sequence: gap=%0d checks=%0d failures=%0d", gap, checks, failures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xor_multi.md
XOR_MULTI -- requirements
Module: xor_multi

Interface
REQ-001 Parameter: width, default 32, operand and result bit width.
REQ-002 Parameter: max_ops, default 16, maximum operands per reduction (min 2).
REQ-003 Parameter: cnt_w, default $clog2(max_ops+1), width of the operand counter.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous and active-high.
REQ-006 Port: in_valid  input  1  operand beat offered.
REQ-007 Port: in_ready  output  1  block can accept an operand this cycle.
REQ-008 Port: input1  input  width  operand data.
REQ-009 Port: in_last  input  1  final operand of current reduction.
REQ-010 Port: mode  input  1  0 = XOR reduction, 1 = XNOR (inverted XOR) result; sampled on first beat only.
REQ-011 Port: result  output  width  reduced value.
REQ-012 Port: out_valid  output  1  result available.
REQ-013 Port: out_ready  input  1  consumer takes result.
REQ-014 Port: count  output  cnt_w  number of operands folded into result.
REQ-015 Port: truncated  output  1  reduction closed by max_ops limit, not by in_last.

Function
REQ-016 Beat accepted when in_valid and in_ready both high on a rising edge; data ignored otherwise.
REQ-017 States SHALL be IDLE, ACCUM, DONE.
REQ-018 IDLE: in_ready=1, out_valid=0; accepted beat loads acc<=input1, count<=1, latches mode.
REQ-019 ACCUM: in_ready=1, out_valid=0; accepted beat does acc<=acc^input1, count<=count+1.
REQ-020 From IDLE or ACCUM: accepted beat with in_last=1 goes to DONE with truncated=0.
REQ-021 Accepted beat that brings count to max_ops without in_last goes to DONE with truncated=1; next beat starts a new reduction.
REQ-022 Accepted beat in IDLE with in_last=0 (and max_ops>1) goes to ACCUM; no beat keeps state.
REQ-023 DONE: in_ready=0, out_valid=1, result = latched mode ? ~acc : acc; result, count, truncated held stable until handshake.
REQ-024 DONE with out_ready=1 returns to IDLE next cycle; out_ready=0 holds DONE indefinitely.
REQ-025 Latency: out_valid rises the cycle after the closing beat is accepted; no combinational path from input1 to result.
REQ-026 Single-beat reduction (in_last on first beat) yields result=input1 (or ~input1), count=1.
REQ-027 Outside DONE, result SHALL be 0 and truncated 0; count shows beats accepted so far.
REQ-028 Counter never exceeds max_ops; no wrap-around possible.

Reset
REQ-029 rst high at a rising edge SHALL force IDLE, acc=0, count=0, latched mode=0, truncated=0, out_valid=0, in_ready=1 on the next cycle.
REQ-030 rst takes priority over any simultaneous handshake; reduction in progress or pending result discarded.

Structure
REQ-031 State encoding (IDLE/ACCUM/DONE) and mode codes SHALL live in shared package cpu_pkg.
REQ-032 Bitwise combine SHALL reuse existing xor_two (width parameter) as the only sub-module; remaining logic in xor_multi.

Verification
REQ-033 Beats 0x00000000, 0xFFFFFFFF(last), mode=0 -> next cycle out_valid=1, result=0xFFFFFFFF, count=2, truncated=0.
REQ-034 Beats 0xF0F0F0F0, 0x0F0F0F0F, 0x0F0F0F0F(last), mode=1 -> result=0x0F0F0F0F, count=3.
REQ-035 Single beat 0x11111111(last), mode=0 -> result=0x11111111, count=1; out_ready held low 5 cycles -> outputs stable, in_ready=0 throughout.
REQ-036 max_ops=4, beats 0x1,0x2,0x4,0x8 no last -> result=0x0000000F, count=4, truncated=1; following beat 0x3(last) -> result=0x3, truncated=0.
REQ-037 Two beats 0x33333333, 0x11111111 then rst=1 one cycle with in_valid high -> IDLE, count=0, out_valid=0; next reduction 0xAAAAAAAA(last) -> result=0xAAAAAAAA.
REQ-038 in_valid toggled randomly with gaps between beats 0x5,0x6(last) -> result=0x3, count=2, gaps not counted.
